// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the general-purpose register file.
package gpr_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_RD = 2;

    // Register address width for a given depth (at least one bit).
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: register mux, write bypass and busy lookup.
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = calc_aw(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rbusy
);

    logic zero_hit;
    logic bypass_hit;

    assign zero_hit   = ZERO_REG && (raddr == '0);
    assign bypass_hit = we && (waddr == raddr);

    // Hardwired zero beats bypass; bypass beats stored state.
    always_comb begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
        if (zero_hit) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (bypass_hit) begin
            rdata = wdata;
            rbusy = busy_set && (busy_addr == raddr);
        end
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port register file with write bypass and per-register busy scoreboard.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  NUM_RD   = DEF_NUM_RD,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    WE,
    input  logic [AW-1:0]           WADDR,
    input  logic [WIDTH-1:0]        WDATA,
    input  logic                    BUSY_SET,
    input  logic [AW-1:0]           BUSY_ADDR,
    input  logic [NUM_RD*AW-1:0]    RADDR,
    output logic [NUM_RD*WIDTH-1:0] RDATA,
    output logic [NUM_RD-1:0]       RBUSY
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_ok;
    logic             set_ok;

    assign wr_ok  = WE && !(ZERO_REG && (WADDR == '0));
    assign set_ok = BUSY_SET && !(ZERO_REG && (BUSY_ADDR == '0));

    // Register array update: reset clears, writeback stores.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[WADDR] <= WDATA;
        end
    end

    // Busy scoreboard: a new issue to a register wins over its writeback clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (set_ok && (BUSY_ADDR == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_ok && (WADDR == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        gpr_rd_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .regs     (regs),
            .busy     (busy),
            .we       (WE),
            .waddr    (WADDR),
            .wdata    (WDATA),
            .busy_set (BUSY_SET),
            .busy_addr(BUSY_ADDR),
            .raddr    (RADDR[k*AW +: AW]),
            .rdata    (RDATA[k*WIDTH +: WIDTH]),
            .rbusy    (RBUSY[k])
        );
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Randomized self-checking bench for gpr_file_mp, plain and zero-register builds.
module tb_gpr_file_mp;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        WE;
    logic [3:0]  WADDR;
    logic [15:0] WDATA;
    logic        BUSY_SET;
    logic [3:0]  BUSY_ADDR;
    logic [7:0]  RADDR;
    logic [31:0] RDATA0, RDATA1;
    logic [1:0]  RBUSY0, RBUSY1;

    int checks = 0;
    int errors = 0;

    // Reference state per build: index 0 = plain, 1 = hardwired zero register.
    logic [15:0] mreg  [2][16];
    logic        mbusy [2][16];

    // Outputs observed in the most recent step: [build][port].
    logic [15:0] obs_d [2][2];
    logic        obs_b [2][2];

    always #5 CLK = ~CLK;

    gpr_file_mp #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .BUSY_SET(BUSY_SET), .BUSY_ADDR(BUSY_ADDR), .RADDR(RADDR),
        .RDATA(RDATA0), .RBUSY(RBUSY0)
    );

    gpr_file_mp #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1'b1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .BUSY_SET(BUSY_SET), .BUSY_ADDR(BUSY_ADDR), .RADDR(RADDR),
        .RDATA(RDATA1), .RBUSY(RBUSY1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected read result for build z at address a under the current inputs.
    function automatic void exp_rd(input int z, input logic [3:0] a,
                                   output logic [15:0] d, output logic b);
        if (z == 1 && a == 4'd0) begin
            d = 16'h0000;
            b = 1'b0;
        end else if (WE && WADDR == a) begin
            d = WDATA;
            b = BUSY_SET && (BUSY_ADDR == a);
        end else begin
            d = mreg[z][a];
            b = mbusy[z][a];
        end
    endfunction

    // One clock cycle: drive, check reads before the edge, then advance the model.
    task automatic step(input bit rst_n, input bit we, input logic [3:0] wa, input logic [15:0] wd,
                        input bit set, input logic [3:0] ba,
                        input logic [3:0] ra0, input logic [3:0] ra1, input bit chk);
        logic [15:0] ed;
        logic        eb;
        logic [3:0]  ra;
        @(negedge CLK);
        RST_N = rst_n; WE = we; WADDR = wa; WDATA = wd;
        BUSY_SET = set; BUSY_ADDR = ba; RADDR = {ra1, ra0};
        #1;
        obs_d[0][0] = RDATA0[15:0];  obs_d[0][1] = RDATA0[31:16];
        obs_b[0][0] = RBUSY0[0];     obs_b[0][1] = RBUSY0[1];
        obs_d[1][0] = RDATA1[15:0];  obs_d[1][1] = RDATA1[31:16];
        obs_b[1][0] = RBUSY1[0];     obs_b[1][1] = RBUSY1[1];
        if (chk) begin
            for (int z = 0; z < 2; z++) begin
                for (int k = 0; k < 2; k++) begin
                    ra = (k == 0) ? ra0 : ra1;
                    exp_rd(z, ra, ed, eb);
                    check_eq($sformatf("b%0d_p%0d_a%0d_data", z, k, ra), {16'h0, obs_d[z][k]}, {16'h0, ed});
                    check_eq($sformatf("b%0d_p%0d_a%0d_busy", z, k, ra), {31'h0, obs_b[z][k]}, {31'h0, eb});
                end
            end
        end
        @(posedge CLK);
        for (int z = 0; z < 2; z++) begin
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) begin
                    mreg[z][i]  = 16'h0;
                    mbusy[z][i] = 1'b0;
                end
            end else begin
                if (we && !(z == 1 && wa == 4'd0)) begin
                    mreg[z][wa]  = wd;
                    mbusy[z][wa] = 1'b0;
                end
                if (set && !(z == 1 && ba == 4'd0)) mbusy[z][ba] = 1'b1;
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
        BUSY_SET = 1'b0; BUSY_ADDR = '0; RADDR = '0;

        // Reset, then scan all addresses on both ports.
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int a = 0; a < 16; a++) begin
            step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'(a), 4'(15 - a), 1'b1);
        end

        // Reset overrides a write in the same cycle.
        step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd3, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd3, 1'b1);
        check_eq("rst_over_we_data", {16'h0, obs_d[0][0]}, 32'h0000);
        check_eq("rst_over_we_busy", {31'h0, obs_b[0][0]}, 32'h0);

        // Plain writes then read back.
        step(1'b1, 1'b1, 4'd5, 16'hA5A5, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd10, 16'h1234, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd10, 1'b1);
        check_eq("rd5", {16'h0, obs_d[0][0]}, 32'hA5A5);
        check_eq("rd10", {16'h0, obs_d[0][1]}, 32'h1234);

        // Same-cycle bypass on both ports.
        step(1'b1, 1'b1, 4'd7, 16'h0F0F, 1'b0, 4'd0, 4'd7, 4'd7, 1'b1);
        check_eq("byp_p0", {16'h0, obs_d[0][0]}, 32'h0F0F);
        check_eq("byp_p1", {16'h0, obs_d[0][1]}, 32'h0F0F);

        // Scoreboard set, then writeback clears with bypass.
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd4, 4'd4, 1'b1);
        check_eq("set_not_yet_visible", {31'h0, obs_b[0][0]}, 32'h0);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd4, 4'd4, 1'b1);
        check_eq("busy4_set", {31'h0, obs_b[0][0]}, 32'h1);
        step(1'b1, 1'b1, 4'd4, 16'h0042, 1'b0, 4'd0, 4'd4, 4'd4, 1'b1);
        check_eq("wb4_busy", {31'h0, obs_b[0][0]}, 32'h0);
        check_eq("wb4_data", {16'h0, obs_d[0][0]}, 32'h0042);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd4, 4'd4, 1'b1);
        check_eq("busy4_clear", {31'h0, obs_b[0][0]}, 32'h0);

        // Simultaneous set and write to the same register: set wins.
        step(1'b1, 1'b1, 4'd2, 16'h7777, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1);
        check_eq("setwr_same_cycle_busy", {31'h0, obs_b[0][0]}, 32'h1);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd2, 4'd2, 1'b1);
        check_eq("setwr_busy", {31'h0, obs_b[0][1]}, 32'h1);
        check_eq("setwr_data", {16'h0, obs_d[0][1]}, 32'h7777);

        // Register 0 in both builds.
        step(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
        check_eq("zr_same_data", {16'h0, obs_d[1][0]}, 32'h0000);
        check_eq("zr_same_busy", {31'h0, obs_b[1][1]}, 32'h0);
        check_eq("nz_r0_byp", {16'h0, obs_d[0][0]}, 32'hFFFF);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        check_eq("zr_after_data", {16'h0, obs_d[1][0]}, 32'h0000);
        check_eq("zr_after_busy", {31'h0, obs_b[1][0]}, 32'h0);
        check_eq("nz_r0_busy", {31'h0, obs_b[0][0]}, 32'h1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
